// File: rtl/tx_pkg.sv
// Shared framing markers and FSM state type for the tx character capture path.
package tx_pkg;

  localparam logic [6:0] TX_START = 7'h00;
  localparam logic [6:0] TX_END   = 7'h7F;

  typedef enum logic {IDLE, CAPTURE} tx_state_t;

endpackage

// File: rtl/tx_fifo.sv
// Show-ahead synchronous FIFO: head entry visible one cycle after push into empty.
// Push is refused when full unless a pop frees the slot in the same cycle.
module tx_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage is never read while empty, so it needs no reset.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/tx_capture.sv
// Frames the tx character stream between 00/7F markers and queues payload characters.
// 1-cycle push-to-out_valid latency; on a full FIFO without a same-cycle pop the character is dropped and overflow latches.
module tx_capture
  import tx_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LEN_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              tx,
  output logic [6:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    in_frame,
  output logic                    frame_done,
  output logic [LEN_W-1:0]        frame_len,
  output logic                    overflow,
  output logic [$clog2(DEPTH):0]  level
);

  tx_state_t        state_q, state_d;
  logic [LEN_W-1:0] frame_len_q, frame_len_d;
  logic             overflow_q, overflow_d;
  logic             frame_done_q, frame_done_d;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;

  assign pop = out_valid && out_ready;

  always_comb begin
    state_d      = state_q;
    frame_len_d  = frame_len_q;
    overflow_d   = overflow_q;
    frame_done_d = 1'b0;
    push         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tx == TX_START) begin
          state_d     = CAPTURE;
          frame_len_d = '0;
        end
      end
      CAPTURE: begin
        if (tx == TX_END) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end else if (tx != TX_START) begin
          // A slot freed by a same-cycle pop still counts as room.
          if (!fifo_full || pop) begin
            push = 1'b1;
            if (frame_len_q != '1) frame_len_d = frame_len_q + LEN_W'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      frame_len_q  <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_len_q  <= frame_len_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  tx_fifo #(
    .WIDTH (7),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push),
    .wdata_i (tx),
    .pop_i   (pop),
    .rdata_o (out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign out_valid  = !fifo_empty;
  assign in_frame   = (state_q == CAPTURE);
  assign frame_done = frame_done_q;
  assign frame_len  = frame_len_q;
  assign overflow   = overflow_q;

endmodule
